// File: rtl/blink_rate_decoder.sv
// Blink rate decoder: measures the half-period of a square wave on GPIO_IN,
// classifies it against nine nominal blink rates and shows the locked rate
// one-hot on LEDR. LEDG carries lock, synchronised input level and a sticky error.
module blink_rate_decoder #(
    parameter int UNIT          = 6_250_000,
    parameter int TOL_SHIFT     = 4,
    parameter int TIMEOUT_UNITS = 40
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic       GPIO_IN,
    output logic [9:0] LEDR,
    output logic [7:0] LEDG
);
    localparam int CNT_W       = 28;
    localparam int NUM_CLASSES = 9;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_UNITS * UNIT);

    typedef enum logic [1:0] {IDLE, ARMED, CAND, LOCKED} state_t;

    logic rst_n;
    logic unused_keys;
    assign rst_n       = KEY[0];
    assign unused_keys = &{1'b0, KEY[3:1]};

    // Input path, interval counter and the two pipeline stages feeding the FSM
    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic             strobe;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_s1_q, strobe_s1_d, tmo_s1_q, tmo_s1_d;
    logic [CNT_W-1:0] interval_s1_q, interval_s1_d;
    logic             strobe_s2_q, strobe_s2_d, tmo_s2_q, tmo_s2_d;
    logic             match_s2_q, match_s2_d;
    logic [3:0]       class_s2_q, class_s2_d;

    // FSM and registered outputs
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic             err_q, err_d, lock_q, lock_d, level_q, level_d;
    logic [9:0]       ledr_q, ledr_d;

    // Nominal half-period of each class, in clock cycles
    function automatic logic [CNT_W-1:0] nominal_of(input int k);
        logic [CNT_W-1:0] nom;
        case (k)
            0:       nom = CNT_W'(32 * UNIT);
            1:       nom = CNT_W'(24 * UNIT);
            2:       nom = CNT_W'(16 * UNIT);
            3:       nom = CNT_W'(12 * UNIT);
            4:       nom = CNT_W'(8 * UNIT);
            5:       nom = CNT_W'(UNIT);
            6:       nom = CNT_W'(2 * UNIT);
            7:       nom = CNT_W'(4 * UNIT);
            default: nom = CNT_W'(6 * UNIT);
        endcase
        return nom;
    endfunction

    // Window test; a saturated counter is never a valid interval
    function automatic logic in_class(input logic [CNT_W-1:0] iv, input int k);
        logic [CNT_W-1:0] nom;
        logic [CNT_W-1:0] tol;
        nom = nominal_of(k);
        tol = nom >> TOL_SHIFT;
        return (iv != CNT_MAX) && (iv >= nom - tol) && (iv <= nom + tol);
    endfunction

    // Class index to LED pattern; the 1 s rate also lights LEDR[9]
    function automatic logic [9:0] decode_rate(input logic [3:0] c);
        logic [9:0] pat;
        pat = 10'd1 << c;
        if (c == 4'd4) pat[9] = 1'b1;
        return pat;
    endfunction

    // Next-state for synchroniser, counter, edge/timeout pipeline and classifier
    always_comb begin
        sync1_d       = GPIO_IN;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        strobe        = sync2_q ^ prev_q;
        if (strobe)
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
        strobe_s1_d   = strobe;
        interval_s1_d = cnt_q;
        tmo_s1_d      = !strobe && (cnt_q == TIMEOUT_CYC);
        strobe_s2_d   = strobe_s1_q;
        tmo_s2_d      = tmo_s1_q;
        match_s2_d    = 1'b0;
        class_s2_d    = 4'd0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (in_class(interval_s1_q, k)) begin
                match_s2_d = 1'b1;
                class_s2_d = 4'(k);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            strobe_s1_q   <= 1'b0;
            interval_s1_q <= '0;
            tmo_s1_q      <= 1'b0;
            strobe_s2_q   <= 1'b0;
            tmo_s2_q      <= 1'b0;
            match_s2_q    <= 1'b0;
            class_s2_q    <= 4'd0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            strobe_s1_q   <= strobe_s1_d;
            interval_s1_q <= interval_s1_d;
            tmo_s1_q      <= tmo_s1_d;
            strobe_s2_q   <= strobe_s2_d;
            tmo_s2_q      <= tmo_s2_d;
            match_s2_q    <= match_s2_d;
            class_s2_q    <= class_s2_d;
        end
    end

    // Lock FSM; a classified strobe wins over a coincident timeout because
    // the timeout flag is suppressed in the strobe cycle
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        err_d   = err_q;
        if (strobe_s2_q) begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (match_s2_q) begin
                        state_d = CAND;
                        cand_d  = class_s2_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CAND, LOCKED: begin
                    if (match_s2_q && class_s2_q == cand_q) begin
                        state_d = LOCKED;
                        err_d   = (state_q == CAND) ? 1'b0 : err_q;
                    end else if (match_s2_q) begin
                        state_d = CAND;
                        cand_d  = class_s2_q;
                    end else begin
                        state_d = ARMED;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_s2_q && state_q != IDLE) begin
            state_d = IDLE;
        end
        lock_d  = (state_d == LOCKED);
        ledr_d  = (state_d == LOCKED) ? decode_rate(cand_d) : 10'd0;
        level_d = sync2_q;
    end

    // FSM and output registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
            level_q <= 1'b0;
            ledr_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
            level_q <= level_d;
            ledr_q  <= ledr_d;
        end
    end

    assign LEDR = ledr_q;
    assign LEDG = {5'b0, err_q, level_q, lock_q};

endmodule
